mac_array_sequencer: RTL and testbench
======================================

// Module: mac_array_sequencer
// PURPOSE
//  Sequences one dot-product job on the 8-lane 8-bit MAC array + adder tree.
//  Takes a job command, streams N weights then N activations from a byte stream
//  into the array via its op/address/data port, issues READ_S, reassembles the
//  3 serialised result bytes into a 19-bit sum and returns it on a valid/ready port.
//  Sits between the host byte interface and the array; the array holds no job state.
// PARAMETERS
//  N_MAC   8   active MAC lanes loaded per job (1..64; array address is 6 bits)
//  DATA_W  8   operand / array data-bus width
//  SUM_W   19  result width (2*DATA_W + log2(N_MAC))
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  cmd_valid    in   1       job request
//  cmd_ready    out  1       high only in IDLE
//  cmd_reuse_w  in   1       1 = skip weight load, keep resident weights
//  in_valid     in   1       operand byte valid
//  in_ready     out  1       high only in LOAD_W / LOAD_A
//  in_data      in   DATA_W  operand byte (weights lane 0..N-1, then activations 0..N-1)
//  arr_op       out  2       array op: 00 LOAD_W, 01 LOAD_A, 10 READ_S, 11 NOP
//  arr_addr     out  6       array lane address
//  arr_data     out  DATA_W  array load data
//  arr_rdata    in   8       array serial result output
//  res_valid    out  1       result available
//  res_ready    in   1       result consumer ready
//  res_sum      out  SUM_W   dot-product result
//  busy         out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, arr_op=NOP, arr_addr=0, arr_data=0, res_valid=0, res_sum=0,
//   lane index=0, w_loaded=0. Reset mid-job aborts immediately; no partial result is produced.
//  All arr_* outputs registered; the array therefore writes lane k 2 edges after its beat.
//  States: IDLE -> LOAD_W -> LOAD_A -> FLUSH -> READ -> WAIT -> CAP2 -> CAP1 -> CAP0 -> RESP -> IDLE.
//  IDLE: cmd_valid&cmd_ready -> LOAD_A if (cmd_reuse_w & w_loaded), else LOAD_W.
//   reuse_w with w_loaded=0 is a full load (weights undefined otherwise).
//  LOAD_W/LOAD_A: beat = in_valid&in_ready; on beat register arr_op=LOAD_x,
//   arr_addr=idx, arr_data=in_data, idx++; no beat -> arr_op=NOP, idx holds (stalls legal).
//   Beat at idx==N_MAC-1: idx<=0, next state (LOAD_W sets w_loaded=1 -> LOAD_A; LOAD_A -> FLUSH).
//  FLUSH: 1 cycle, array consumes last LOAD_A; register arr_op=READ_S.
//  READ: arr_op=READ_S presented exactly 1 cycle (call it R); register arr_op=NOP.
//  Array drives arr_rdata in R+2 = {5'bx, sum[18:16]}, R+3 = sum[15:8], R+4 = sum[7:0].
//   WAIT = R+1; CAPn samples at end of R+2..R+4; upper 5 bits of the first byte ignored.
//  RESP: res_valid=1 from R+5; res_sum stable until res_valid&res_ready; then IDLE.
//   res_ready may be high before res_valid; back-pressure holds RESP indefinitely.
//  arr_op is NOP in every cycle not listed above; only one op ever in flight.
//  Full-load job, no stalls: cmd accept edge to res_valid = 2*N_MAC + 5 cycles.
//  cmd_valid while busy is ignored (cmd_ready=0); in_valid outside load states ignored.
//  No overflow possible: max 8*255*255 = 520200 < 2^19.
// STRUCTURE
//  Shared package: array op-code constants (OP_LOAD_W/OP_LOAD_A/OP_READ_S/OP_NOP),
//   state enum, SUM_W derivation.
//  One sub-module: seq_result_deser (3-byte shift/capture into SUM_W register with
//   load-enable per byte); FSM, index counter, w_loaded flag stay in the top.
// TESTING (bench uses behavioural array model honouring the R+2..R+4 timing)
//  W=1..8, A=1..8, no stalls -> res_sum=204 (0x000CC), res_valid at accept+21 cycles.
//  W=A=255 all lanes -> res_sum=520200 (0x7F008); bytes 0x07,0xF0,0x08 captured.
//  Then reuse_w=1, A=2 x8 with W=1..8 resident -> only 8 in beats taken, res_sum=72.
//  in_valid toggled 1-of-3 cycles during load -> arr_op NOP in gaps, lane order intact, sum unchanged.
//  res_ready low 10 cycles in RESP -> res_valid/res_sum held; cmd_ready stays 0.
//  rst_n low mid LOAD_A -> all outputs to reset values; next job with reuse_w=1 does full load.

Source files
------------

// File: rtl/mac_array_sequencer_pkg.sv
// Shared definitions for the MAC-array job sequencer: array op-codes, FSM states
// and the result-width derivation.
package mac_array_sequencer_pkg;

  localparam logic [1:0] OP_LOAD_W = 2'b00;
  localparam logic [1:0] OP_LOAD_A = 2'b01;
  localparam logic [1:0] OP_READ_S = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_W, S_LOAD_A, S_FLUSH, S_READ,
    S_WAIT, S_CAP2, S_CAP1, S_CAP0, S_RESP
  } state_e;

  // Product width plus adder-tree growth.
  function automatic int sum_w(input int n_mac, input int data_w);
    return 2 * data_w + $clog2(n_mac);
  endfunction

endpackage

// File: rtl/mac_array_sequencer_deser.sv
// Reassembles the array's three serialised result bytes (MSB first) into the sum.
// The first byte carries only the top SUM_W-16 bits; the rest of it is ignored.
module seq_result_deser #(
  parameter int SUM_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_i,
  input  logic             ld_hi_i,
  input  logic             ld_mid_i,
  input  logic             ld_lo_i,
  output logic [SUM_W-1:0] sum_o
);

  localparam logic [7:0] HI_MASK = 8'((1 << (SUM_W - 16)) - 1);

  logic [SUM_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      if (ld_hi_i)  sum_q <= SUM_W'({byte_i & HI_MASK, 16'h0000});
      if (ld_mid_i) sum_q[15:8] <= byte_i;
      if (ld_lo_i)  sum_q[7:0]  <= byte_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mac_array_sequencer.sv
// Sequences one dot-product job on the MAC array: weight/activation streaming,
// READ_S issue, result capture and a valid/ready result port.
module mac_array_sequencer
  import mac_array_sequencer_pkg::*;
#(
  parameter int N_MAC  = 8,
  parameter int DATA_W = 8,
  parameter int SUM_W  = sum_w(N_MAC, DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_reuse_w,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [1:0]        arr_op,
  output logic [5:0]        arr_addr,
  output logic [DATA_W-1:0] arr_data,
  input  logic [7:0]        arr_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SUM_W-1:0]  res_sum,
  output logic              busy
);

  localparam logic [5:0] LAST = 6'(N_MAC - 1);

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic              w_loaded_q, w_loaded_d;
  logic [1:0]        arr_op_q, arr_op_d;
  logic [5:0]        arr_addr_q, arr_addr_d;
  logic [DATA_W-1:0] arr_data_q, arr_data_d;
  logic              ld_hi, ld_mid, ld_lo;
  logic              beat;

  assign in_ready = (state_q == S_LOAD_W) || (state_q == S_LOAD_A);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign beat      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      w_loaded_q <= 1'b0;
      arr_op_q   <= OP_NOP;
      arr_addr_q <= '0;
      arr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      w_loaded_q <= w_loaded_d;
      arr_op_q   <= arr_op_d;
      arr_addr_q <= arr_addr_d;
      arr_data_q <= arr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    w_loaded_d = w_loaded_q;
    arr_op_d   = OP_NOP;
    arr_addr_d = arr_addr_q;
    arr_data_d = arr_data_q;
    ld_hi      = 1'b0;
    ld_mid     = 1'b0;
    ld_lo      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Reuse is only honoured once a full weight set has landed in the array.
        if (cmd_valid) state_d = (cmd_reuse_w && w_loaded_q) ? S_LOAD_A : S_LOAD_W;
      end
      S_LOAD_W, S_LOAD_A: begin
        if (beat) begin
          arr_op_d   = (state_q == S_LOAD_W) ? OP_LOAD_W : OP_LOAD_A;
          arr_addr_d = idx_q;
          arr_data_d = in_data;
          if (idx_q == LAST) begin
            idx_d = '0;
            if (state_q == S_LOAD_W) begin
              w_loaded_d = 1'b1;
              state_d    = S_LOAD_A;
            end else begin
              state_d = S_FLUSH;
            end
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_FLUSH: begin
        arr_op_d = OP_READ_S;
        state_d  = S_READ;
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_CAP2;
      S_CAP2: begin
        ld_hi   = 1'b1;
        state_d = S_CAP1;
      end
      S_CAP1: begin
        ld_mid  = 1'b1;
        state_d = S_CAP0;
      end
      S_CAP0: begin
        ld_lo   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  seq_result_deser #(.SUM_W(SUM_W)) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_i   (arr_rdata),
    .ld_hi_i  (ld_hi),
    .ld_mid_i (ld_mid),
    .ld_lo_i  (ld_lo),
    .sum_o    (res_sum)
  );

  assign arr_op   = arr_op_q;
  assign arr_addr = arr_addr_q;
  assign arr_data = arr_data_q;

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Randomised job bench: behavioural MAC array model plus a dot-product reference.
module tb_mac_array_sequencer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_reuse_w;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic [1:0]  arr_op;
  logic [5:0]  arr_addr;
  logic [7:0]  arr_data;
  logic [7:0]  arr_rdata;
  logic        res_valid, res_ready;
  logic [18:0] res_sum;
  logic        busy;

  mac_array_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reuse_w(cmd_reuse_w),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_op(arr_op), .arr_addr(arr_addr), .arr_data(arr_data), .arr_rdata(arr_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Behavioural array: lane storage, READ_S answered with 3 bytes in R+2..R+4.
  logic [7:0] aw [64];
  logic [7:0] aa [64];
  int         s_lat;
  int         ph = 0;

  always @(posedge clk) begin
    case (ph)
      1:       arr_rdata <= {5'($urandom_range(31)), 3'(s_lat >> 16)};
      2:       arr_rdata <= 8'(s_lat >> 8);
      3:       arr_rdata <= 8'(s_lat);
      default: arr_rdata <= 8'($urandom_range(255));
    endcase
    ph = (ph >= 1 && ph < 3) ? ph + 1 : 0;
    case (arr_op)
      2'b00: aw[arr_addr] = arr_data;
      2'b01: aa[arr_addr] = arr_data;
      2'b10: begin
        s_lat = 0;
        for (int k = 0; k < N; k++) s_lat += int'(aw[k]) * int'(aa[k]);
        ph = 1;
      end
      default: ;
    endcase
  end

  // Reference view of what the sequencer should consider resident.
  bit wl_ref = 1'b0;
  int res_w [N];

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_arr_op"}, 32'(arr_op), 32'd3);
    chk({pfx, "_arr_addr"}, 32'(arr_addr), 32'd0);
    chk({pfx, "_arr_data"}, 32'(arr_data), 32'd0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({pfx, "_res_sum"}, 32'(res_sum), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic run_job(input bit reuse, input int wv[N], input int av[N],
                         input bit stall, input int bp, input int abort_at);
    int  stream [2*N];
    int  nb, nw, ptr, guard, c0, exp_sum;
    bit  full, beat;
    full = !(reuse && wl_ref);
    nw   = full ? N : 0;
    nb   = nw + N;
    for (int k = 0; k < N; k++) begin
      if (full) stream[k] = wv[k];
      stream[nw + k] = av[k];
    end
    if (full) res_w = wv;
    exp_sum = 0;
    for (int k = 0; k < N; k++) exp_sum += res_w[k] * av[k];

    guard = 0;
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_reuse_w = reuse;
    res_ready   = (bp == 0);
    @(negedge clk);
    c0 = cyc;
    cmd_valid = stall;  // extra commands while busy must be ignored
    chk("busy_after_accept", 32'(busy), 32'd1);

    ptr = 0; guard = 0;
    while (ptr < nb && guard < 2000) begin
      if (abort_at >= 0 && ptr == abort_at) break;
      in_valid = stall ? (guard % 3 == 0) : 1'b1;
      in_data  = 8'(stream[ptr]);
      beat     = in_valid && in_ready;
      @(negedge clk);
      guard++;
      if (beat) begin
        chk("beat_op", 32'(arr_op), (ptr < nw) ? 32'd0 : 32'd1);
        chk("beat_addr", 32'(arr_addr), 32'(ptr % N));
        chk("beat_data", 32'(arr_data), 32'(stream[ptr]));
        ptr++;
      end else begin
        chk("gap_op_nop", 32'(arr_op), 32'd3);
      end
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;

    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      wl_ref = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end

    chk("load_timeout", 32'(guard < 2000), 32'd1);
    chk("in_ready_after_stream", 32'(in_ready), 32'd0);
    if (full) wl_ref = 1'b1;

    guard = 0;
    while (!res_valid && guard < 100) begin
      in_valid = 1'b1;  // ignored outside load states
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    chk("res_valid_seen", 32'(res_valid), 32'd1);
    if (!stall) chk("latency", 32'(cyc - c0 - 1), 32'(nb + 5));
    chk("res_sum", 32'(res_sum), 32'(exp_sum));

    for (int i = 0; i < bp; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_sum", 32'(res_sum), 32'(exp_sum));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    res_ready = 1'b0;
  endtask

  int wv [N];
  int av [N];

  task automatic rand_vecs();
    for (int k = 0; k < N; k++) begin
      wv[k] = int'($urandom_range(255));
      av[k] = int'($urandom_range(255));
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_reuse_w = 1'b0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) begin wv[k] = k + 1; av[k] = k + 1; end
    run_job(1'b0, wv, av, 1'b0, 0, -1);            // 204

    for (int k = 0; k < N; k++) av[k] = 2;
    run_job(1'b1, wv, av, 1'b0, 0, -1);            // 72, activations only

    for (int k = 0; k < N; k++) begin wv[k] = 255; av[k] = 255; end
    run_job(1'b0, wv, av, 1'b0, 0, -1);            // 520200

    rand_vecs();
    run_job(1'b0, wv, av, 1'b1, 0, -1);            // 1-of-3 stalls
    rand_vecs();
    run_job(1'b1, wv, av, 1'b0, 10, -1);           // back-pressure
    rand_vecs();
    run_job(1'b0, wv, av, 1'b0, 0, N + 3);         // reset mid LOAD_A
    rand_vecs();
    run_job(1'b1, wv, av, 1'b0, 0, -1);            // reuse after reset -> full load

    for (int j = 0; j < 6; j++) begin
      rand_vecs();
      run_job(1'($urandom_range(1)), wv, av, 1'($urandom_range(1)),
              int'($urandom_range(3)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
